// File: rtl/cpu6502_interrupt_controller_if.sv
// Interrupt front-end bus: CPU microsequencer (master) <-> interrupt controller (slave).
interface cpu6502_interrupt_controller_if;
  logic        enable;
  logic        nNMI;
  logic        nIRQ;
  logic        iFlag;
  logic        pollStrobe;
  logic        serviceStart;
  logic        brkOpcode;
  logic        vectorLatch;
  logic        vectorAck;
  logic        interruptRequest;
  logic [15:0] vectorAddress;
  logic        vectorIsNmi;
  logic        pushBFlag;
  logic        resetSequence;

  modport master (
    output enable, nNMI, nIRQ, iFlag, pollStrobe, serviceStart, brkOpcode,
           vectorLatch, vectorAck,
    input  interruptRequest, vectorAddress, vectorIsNmi, pushBFlag, resetSequence
  );

  modport slave (
    input  enable, nNMI, nIRQ, iFlag, pollStrobe, serviceStart, brkOpcode,
           vectorLatch, vectorAck,
    output interruptRequest, vectorAddress, vectorIsNmi, pushBFlag, resetSequence
  );
endinterface

// File: rtl/cpu6502_interrupt_controller.sv
// 6502 interrupt front end: pin synchronisers, NMI edge latch, poll decision,
// vector selection with NMI hijack, and reset-sequence tracking.
// All state advances on the falling clock edge, qualified by enable.
module cpu6502_interrupt_controller #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [15:0] NMI_VECTOR   = 16'hFFFA,
  parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE
) (
  input  logic                           clock,
  input  logic                           reset,
  cpu6502_interrupt_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RESET_SEQ = 2'd1,
    ST_SERVICE   = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] nmiSync_q, nmiSync_d;
  logic [SYNC_STAGES-1:0] irqSync_q, irqSync_d;
  logic                   nmiPrev_q, nmiPrev_d;
  logic                   nmiLatch_q, nmiLatch_d;
  state_t                 state_q, state_d;
  // Set for a sequence started from reset; doubles as resetSequence.
  logic                   fromReset_q, fromReset_d;
  logic                   intReq_q, intReq_d;
  logic [15:0]            vecAddr_q, vecAddr_d;
  logic                   vecIsNmi_q, vecIsNmi_d;
  logic                   pushB_q, pushB_d;

  logic                   nmiSync;
  logic                   irqSync;
  logic                   nmiEdge;
  logic                   irqActive;

  assign nmiSync   = nmiSync_q[SYNC_STAGES-1];
  assign irqSync   = irqSync_q[SYNC_STAGES-1];
  assign nmiEdge   = nmiPrev_q & ~nmiSync;
  assign irqActive = ~irqSync & ~bus.iFlag;

  // State register: falling edge, async reset, everything frozen when enable=0.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      nmiSync_q   <= '1;
      irqSync_q   <= '1;
      nmiPrev_q   <= 1'b1;
      nmiLatch_q  <= 1'b0;
      state_q     <= ST_RESET_SEQ;
      fromReset_q <= 1'b1;
      intReq_q    <= 1'b1;
      vecAddr_q   <= RESET_VECTOR;
      vecIsNmi_q  <= 1'b0;
      pushB_q     <= 1'b0;
    end else if (bus.enable) begin
      nmiSync_q   <= nmiSync_d;
      irqSync_q   <= irqSync_d;
      nmiPrev_q   <= nmiPrev_d;
      nmiLatch_q  <= nmiLatch_d;
      state_q     <= state_d;
      fromReset_q <= fromReset_d;
      intReq_q    <= intReq_d;
      vecAddr_q   <= vecAddr_d;
      vecIsNmi_q  <= vecIsNmi_d;
      pushB_q     <= pushB_d;
    end
  end

  // Next-state: synchroniser shift, NMI latch, poll decision and sequence control.
  always_comb begin
    nmiSync_d   = {nmiSync_q[SYNC_STAGES-2:0], bus.nNMI};
    irqSync_d   = {irqSync_q[SYNC_STAGES-2:0], bus.nIRQ};
    nmiPrev_d   = nmiSync;
    nmiLatch_d  = nmiLatch_q;
    state_d     = state_q;
    fromReset_d = fromReset_q;
    intReq_d    = intReq_q;
    vecAddr_d   = vecAddr_q;
    vecIsNmi_d  = vecIsNmi_q;
    pushB_d     = pushB_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.pollStrobe) intReq_d = nmiLatch_q | irqActive;
        if (bus.serviceStart) begin
          state_d     = ST_SERVICE;
          fromReset_d = 1'b0;
          pushB_d     = bus.brkOpcode;
          intReq_d    = 1'b0;
        end
      end
      ST_RESET_SEQ: begin
        if (bus.serviceStart) begin
          state_d  = ST_SERVICE;
          pushB_d  = 1'b0;
          intReq_d = 1'b0;
        end
      end
      ST_SERVICE: begin
        if (bus.vectorLatch) begin
          if (fromReset_q) begin
            vecAddr_d  = RESET_VECTOR;
            vecIsNmi_d = 1'b0;
          end else if (nmiLatch_q) begin
            vecAddr_d  = NMI_VECTOR;
            vecIsNmi_d = 1'b1;
          end else begin
            vecAddr_d  = IRQ_VECTOR;
            vecIsNmi_d = 1'b0;
          end
        end
        if (bus.vectorAck) begin
          state_d     = ST_IDLE;
          fromReset_d = 1'b0;
          if (vecIsNmi_q) nmiLatch_d = 1'b0;
        end
      end
      default: state_d = ST_RESET_SEQ;
    endcase

    // A fresh edge beats a same-cycle acknowledge clear.
    if (nmiEdge) nmiLatch_d = 1'b1;
  end

  assign bus.interruptRequest = intReq_q;
  assign bus.vectorAddress    = vecAddr_q;
  assign bus.vectorIsNmi      = vecIsNmi_q;
  assign bus.pushBFlag        = pushB_q;
  assign bus.resetSequence    = fromReset_q;

endmodule

// File: tb/tb_cpu6502_interrupt_controller.sv
// Directed bench for cpu6502_interrupt_controller. Inputs change and outputs
// are sampled on the rising edge; the DUT updates on the falling edge.
module tb_cpu6502_interrupt_controller;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  cpu6502_interrupt_controller_if bus();

  cpu6502_interrupt_controller #(
    .SYNC_STAGES (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(posedge clock);
  endtask

  task automatic do_poll();
    bus.pollStrobe = 1'b1; tick(); bus.pollStrobe = 1'b0;
  endtask

  task automatic do_start(input logic brk);
    bus.serviceStart = 1'b1; bus.brkOpcode = brk; tick();
    bus.serviceStart = 1'b0; bus.brkOpcode = 1'b0;
  endtask

  task automatic do_latch();
    bus.vectorLatch = 1'b1; tick(); bus.vectorLatch = 1'b0;
  endtask

  task automatic do_ack();
    bus.vectorAck = 1'b1; tick(); bus.vectorAck = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.enable = 1'b1; bus.nNMI = 1'b1; bus.nIRQ = 1'b1; bus.iFlag = 1'b0;
    bus.pollStrobe = 1'b0; bus.serviceStart = 1'b0; bus.brkOpcode = 1'b0;
    bus.vectorLatch = 1'b0; bus.vectorAck = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    check_eq("rst_ireq",   {31'd0, bus.interruptRequest}, 32'd1);
    check_eq("rst_rseq",   {31'd0, bus.resetSequence},    32'd1);
    check_eq("rst_vaddr",  {16'd0, bus.vectorAddress},    32'h0000FFFC);
    check_eq("rst_isnmi",  {31'd0, bus.vectorIsNmi},      32'd0);
    check_eq("rst_pushb",  {31'd0, bus.pushBFlag},        32'd0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // Reset sequence: poll ignored, vector FFFC, resetSequence drops on ack.
    do_poll();
    check_eq("rseq_poll_ignored", {31'd0, bus.interruptRequest}, 32'd1);
    do_start(1'b0);
    check_eq("rseq_ireq_clr", {31'd0, bus.interruptRequest}, 32'd0);
    check_eq("rseq_still",    {31'd0, bus.resetSequence},    32'd1);
    check_eq("rseq_pushb",    {31'd0, bus.pushBFlag},        32'd0);
    do_latch();
    check_eq("rseq_vaddr",    {16'd0, bus.vectorAddress},    32'h0000FFFC);
    check_eq("rseq_rseq_pre_ack", {31'd0, bus.resetSequence}, 32'd1);
    do_ack();
    check_eq("rseq_done",     {31'd0, bus.resetSequence},    32'd0);

    // IRQ level with I clear, then masked by I.
    bus.nIRQ = 1'b0;
    tick(2);
    do_poll();
    check_eq("irq_ireq", {31'd0, bus.interruptRequest}, 32'd1);
    do_start(1'b0);
    check_eq("irq_pushb", {31'd0, bus.pushBFlag}, 32'd0);
    do_latch();
    check_eq("irq_vaddr", {16'd0, bus.vectorAddress}, 32'h0000FFFE);
    check_eq("irq_isnmi", {31'd0, bus.vectorIsNmi},   32'd0);
    do_ack();
    bus.iFlag = 1'b1;
    do_poll();
    check_eq("irq_masked", {31'd0, bus.interruptRequest}, 32'd0);
    bus.nIRQ = 1'b1;
    bus.iFlag = 1'b0;
    tick(3);

    // NMI latency of three enabled edges, held low for 20 cycles.
    bus.nNMI = 1'b0;
    tick();
    check_eq("nmi_lat_e1", {31'd0, dut.nmiLatch_q}, 32'd0);
    tick();
    check_eq("nmi_lat_e2", {31'd0, dut.nmiLatch_q}, 32'd0);
    tick();
    check_eq("nmi_lat_e3", {31'd0, dut.nmiLatch_q}, 32'd1);
    tick(17);
    do_poll();
    check_eq("nmi_ireq", {31'd0, bus.interruptRequest}, 32'd1);
    do_start(1'b0);
    do_latch();
    check_eq("nmi_vaddr", {16'd0, bus.vectorAddress}, 32'h0000FFFA);
    check_eq("nmi_isnmi", {31'd0, bus.vectorIsNmi},   32'd1);
    do_ack();
    check_eq("nmi_cleared", {31'd0, dut.nmiLatch_q}, 32'd0);
    do_poll();
    check_eq("nmi_no_retrigger", {31'd0, bus.interruptRequest}, 32'd0);
    bus.nNMI = 1'b1;
    tick(4);

    // BRK hijacked by NMI arriving before vectorLatch.
    do_start(1'b1);
    check_eq("brk_pushb", {31'd0, bus.pushBFlag}, 32'd1);
    bus.nNMI = 1'b0;
    tick(3);
    do_latch();
    check_eq("hij_vaddr", {16'd0, bus.vectorAddress}, 32'h0000FFFA);
    check_eq("hij_isnmi", {31'd0, bus.vectorIsNmi},   32'd1);
    check_eq("hij_pushb", {31'd0, bus.pushBFlag},     32'd1);
    do_ack();
    bus.nNMI = 1'b1;
    tick(4);

    // NMI after vectorLatch: BRK vector kept, NMI stays pending.
    do_start(1'b1);
    do_latch();
    bus.nNMI = 1'b0;
    tick(3);
    check_eq("late_vaddr", {16'd0, bus.vectorAddress}, 32'h0000FFFE);
    check_eq("late_isnmi", {31'd0, bus.vectorIsNmi},   32'd0);
    do_ack();
    do_poll();
    check_eq("late_pending", {31'd0, bus.interruptRequest}, 32'd1);
    do_start(1'b0);
    do_latch();
    check_eq("late_nmi_vaddr", {16'd0, bus.vectorAddress}, 32'h0000FFFA);
    do_ack();
    bus.nNMI = 1'b1;
    tick(4);

    // enable=0: NMI toggling and a live IRQ poll must change nothing.
    bus.enable = 1'b0;
    bus.nIRQ = 1'b0;
    bus.pollStrobe = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.nNMI = ~bus.nNMI;
      tick();
    end
    check_eq("hold_ireq",  {31'd0, bus.interruptRequest}, 32'd0);
    check_eq("hold_latch", {31'd0, dut.nmiLatch_q},       32'd0);
    check_eq("hold_vaddr", {16'd0, bus.vectorAddress},    32'h0000FFFA);
    bus.pollStrobe = 1'b0;
    bus.nIRQ = 1'b1;
    bus.nNMI = 1'b1;
    tick();
    bus.enable = 1'b1;
    tick(3);

    // Reset mid-SERVICE with an NMI pending.
    bus.nNMI = 1'b0;
    tick(3);
    do_start(1'b0);
    check_eq("pre_rst_latch", {31'd0, dut.nmiLatch_q}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_ireq",  {31'd0, bus.interruptRequest}, 32'd1);
    check_eq("mid_rst_rseq",  {31'd0, bus.resetSequence},    32'd1);
    check_eq("mid_rst_vaddr", {16'd0, bus.vectorAddress},    32'h0000FFFC);
    check_eq("mid_rst_latch", {31'd0, dut.nmiLatch_q},       32'd0);
    bus.nNMI = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    do_poll();
    check_eq("post_rst_ireq", {31'd0, bus.interruptRequest}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu6502_interrupt_controller.md
Name: cpu6502_interrupt_controller

Overview:
Interrupt front end that sits directly upstream of the 6502 CPU core's microsequencer. It synchronises the raw nNMI/nIRQ pins and edge-detects NMI. At the microcode poll point it decides whether the next opcode fetch becomes an interrupt sequence. During that sequence it supplies the vector address, the B-flag value to push, and the reset-sequence write suppression, including NMI hijack of BRK/IRQ.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on nNMI and nIRQ (legal values 2 to 4).
RESET_VECTOR, 16'hFFFC, vector low-byte address used for the reset sequence.
NMI_VECTOR, 16'hFFFA, vector low-byte address used for NMI.
IRQ_VECTOR, 16'hFFFE, vector low-byte address used for IRQ and BRK.

Ports:
clock  input  1  CPU clock; all state updates on the falling edge, matching CPU microinstruction timing.
reset  input  1  asynchronous, active-high reset.
enable  input  1  clock enable; state updates only on edges where enable=1.
nNMI  input  1  raw NMI pin, active low, asynchronous.
nIRQ  input  1  raw IRQ pin, active low, asynchronous.
iFlag  input  1  I bit of the CPU P register.
pollStrobe  input  1  microcode marker for the interrupt sample cycle (second-to-last cycle of an instruction).
serviceStart  input  1  microcode is entering a BRK or interrupt sequence (one cycle).
brkOpcode  input  1  qualifies serviceStart: 1 = software BRK, 0 = hardware or reset sequence.
vectorLatch  input  1  microcode cycle at which the vector choice is frozen (hijack decision point).
vectorAck  input  1  vector high byte has been fetched; the sequence is complete.
interruptRequest  output  1  the next opcode fetch must be replaced by the interrupt sequence.
vectorAddress  output  16  address of the vector low byte for the current sequence.
vectorIsNmi  output  1  the frozen vector is NMI.
pushBFlag  output  1  B bit value for the pushed P: 1 for BRK, 0 for hardware.
resetSequence  output  1  reset sequence in progress; the CPU converts stack writes into reads.

Behaviour:
- All registers update only on falling clock edges with enable=1. With enable=0 every register, including the synchronisers, holds its value.
- Values while reset is asserted: synchroniser flops and NMI delay flop = 1; nmiLatch = 0; state = RESET_SEQ; interruptRequest = 1; resetSequence = 1; vectorAddress = RESET_VECTOR; vectorIsNmi = 0; pushBFlag = 0.
- Synchronisers: nNMI and nIRQ each pass through a SYNC_STAGES-deep flop chain, producing nmiSync and irqSync.
- NMI edge detect:
  - nmiPrev holds the previous value of nmiSync.
  - nmiLatch is set on the edge where nmiPrev=1 and nmiSync=0.
  - Latency from the first enabled edge that samples nNMI low to nmiLatch=1 is SYNC_STAGES+1 edges (3 by default).
  - Holding nNMI low never retriggers; a new NMI needs a return high and a fresh fall.
  - nmiLatch is cleared on vectorAck when vectorIsNmi=1. If a new edge is detected on the same edge as that clear, the set wins.
- IRQ: irqActive = ~irqSync & ~iFlag. It is level-sensitive and not latched.
- State machine (IDLE, RESET_SEQ, SERVICE):
  - IDLE:
    - On pollStrobe, interruptRequest <= nmiLatch | irqActive.
    - Outside pollStrobe, interruptRequest holds its value.
    - On serviceStart: state -> SERVICE; pushBFlag <= brkOpcode; interruptRequest <= 0.
  - RESET_SEQ:
    - Entered on reset. interruptRequest and resetSequence stay 1.
    - pollStrobe is ignored.
    - On serviceStart: state -> SERVICE with reset source kept; pushBFlag <= 0; interruptRequest <= 0.
  - SERVICE:
    - pollStrobe is ignored, so the handler's first instruction always executes.
    - On vectorLatch the vector is frozen:
      - reset source -> RESET_VECTOR, vectorIsNmi = 0;
      - else if nmiLatch=1 -> NMI_VECTOR, vectorIsNmi = 1 (hijack, applies to BRK and IRQ alike; pushBFlag is unchanged);
      - else -> IRQ_VECTOR, vectorIsNmi = 0.
    - An NMI edge detected after vectorLatch leaves the frozen vector unchanged and stays pending for the next poll.
    - On vectorAck: state -> IDLE; resetSequence <= 0; clear nmiLatch if vectorIsNmi=1.
- vectorAddress is registered and reflects the last frozen vector. It holds until the next vectorLatch.
- vectorLatch or vectorAck arriving outside SERVICE is ignored. serviceStart arriving during SERVICE is ignored.
- Reset asserted mid-sequence aborts immediately to the reset values above. After release the block restarts in RESET_SEQ.

Test Plan:
- Release reset, then pulse serviceStart (brkOpcode=0), vectorLatch, vectorAck -> vectorAddress=16'hFFFC, resetSequence 1 until vectorAck then 0, pushBFlag=0, state IDLE.
- In IDLE with iFlag=0, drive nIRQ low and wait 2 edges, then pulse pollStrobe -> interruptRequest=1; complete the sequence -> vectorAddress=16'hFFFE, vectorIsNmi=0. Repeat with iFlag=1 -> interruptRequest=0.
- Drive nNMI high-to-low and hold it low for 20 cycles -> nmiLatch=1 after exactly 3 enabled edges. After one NMI service with vectorAck, a later pollStrobe -> interruptRequest=0 (no retrigger).
- BRK hijack: serviceStart with brkOpcode=1, then an NMI edge lands before vectorLatch -> vectorAddress=16'hFFFA, vectorIsNmi=1, pushBFlag=1. With the edge landing after vectorLatch -> vectorAddress=16'hFFFE and NMI still pending at the next poll.
- Hold enable=0 for 10 cycles while toggling nNMI -> no state change. Assert reset during SERVICE -> immediate interruptRequest=1, resetSequence=1, vectorAddress=16'hFFFC, nmiLatch cleared.
